// File: rtl/minmax_tracker_4bit_pkg.sv
// Shared definitions for the min/max tracker: data width, comparator
// result encoding, FSM state encoding and comparator decode helpers.
package minmax_pkg;

  localparam int DATA_W = 4;

  // One-hot comparator result: bit2=GT, bit1=EQ, bit0=LT
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Only an exact one-hot GT code counts as "greater"
  function automatic logic cmpIsGt(input logic [2:0] res);
    return (res == CMP_GT);
  endfunction

  // Only an exact one-hot LT code counts as "less"
  function automatic logic cmpIsLt(input logic [2:0] res);
    return (res == CMP_LT);
  endfunction

  // EQ and every malformed (non-one-hot) code collapse to "equal"
  function automatic logic cmpIsEq(input logic [2:0] res);
    return !cmpIsGt(res) && !cmpIsLt(res);
  endfunction

endpackage

// File: rtl/minmax_tracker_4bit_if.sv
// Sample-stream and result bundle for minmax_tracker_4bit.
// Optional macro MINMAX_TIE_COUNT_EN adds the tie_count_out result.
interface minmax_tracker_4bit_if #(
  parameter int CNT_W = 4
);
  import minmax_pkg::*;

  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] max_out;
  logic [DATA_W-1:0] min_out;
  logic [CNT_W-1:0]  count_out;
  logic              busy;
  logic              done;
`ifdef MINMAX_TIE_COUNT_EN
  logic [CNT_W-1:0]  tie_count_out;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, max_out, min_out, count_out, busy, done, tie_count_out
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, max_out, min_out, count_out, busy, done, tie_count_out
  );
`else
  modport master (
    output start, in_data, in_valid,
    input  in_ready, max_out, min_out, count_out, busy, done
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, max_out, min_out, count_out, busy, done
  );
`endif

endinterface

// File: rtl/minmax_tracker_4bit_comparator.sv
// Unsigned 4-bit magnitude comparator producing a one-hot GT/EQ/LT code.
module Comparator_4bit
  import minmax_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [2:0]        result_o
);

  // Compare A against B; EQ is the fall-through result
  always_comb begin
    result_o = CMP_EQ;
    if (a_i > b_i) begin
      result_o = CMP_GT;
    end else if (a_i < b_i) begin
      result_o = CMP_LT;
    end
  end

endmodule

// File: rtl/minmax_tracker_4bit.sv
// Windowed running max/min tracker fed by a valid/ready sample stream.
// Optional macro MINMAX_TIE_COUNT_EN counts samples equal to the current max.
module minmax_tracker_4bit
  import minmax_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  minmax_tracker_4bit_if.slave bus
);

  localparam logic [CNT_W-1:0] WINDOW_CNT = CNT_W'(WINDOW);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              first_q, first_d;
`ifdef MINMAX_TIE_COUNT_EN
  logic [CNT_W-1:0]  tieCount_q, tieCount_d;
`endif

  logic [2:0] cmpMax;
  logic [2:0] cmpMin;
  logic       inReady;
  logic       accept;
  logic       lastAccept;
  logic       startWindow;

  Comparator_4bit uCmpMax (
    .a_i      (bus.in_data),
    .b_i      (max_q),
    .result_o (cmpMax)
  );

  Comparator_4bit uCmpMin (
    .a_i      (bus.in_data),
    .b_i      (min_q),
    .result_o (cmpMin)
  );

  assign inReady     = (state_q == S_ACCUM);
  assign accept      = bus.in_valid & inReady;
  assign lastAccept  = accept && ((count_q + CNT_W'(1)) == WINDOW_CNT);
  assign startWindow = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Window sequencing: start only honoured in IDLE/DONE, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_ACCUM;
      S_ACCUM: if (lastAccept) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_ACCUM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result update: first sample seeds max/min, later ones go through the comparators
  always_comb begin
    max_d   = max_q;
    min_d   = min_q;
    count_d = count_q;
    first_d = first_q;
`ifdef MINMAX_TIE_COUNT_EN
    tieCount_d = tieCount_q;
`endif
    if (startWindow) begin
      count_d = '0;
      first_d = 1'b1;
`ifdef MINMAX_TIE_COUNT_EN
      tieCount_d = '0;
`endif
    end else if (accept) begin
      count_d = count_q + CNT_W'(1);
      first_d = 1'b0;
      if (first_q) begin
        max_d = bus.in_data;
        min_d = bus.in_data;
      end else begin
        if (cmpIsGt(cmpMax)) max_d = bus.in_data;
        if (cmpIsLt(cmpMin)) min_d = bus.in_data;
`ifdef MINMAX_TIE_COUNT_EN
        if (cmpIsEq(cmpMax)) tieCount_d = tieCount_q + CNT_W'(1);
`endif
      end
    end
  end

  // State and result registers; reset clears everything without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      min_q   <= '1;
      count_q <= '0;
      first_q <= 1'b0;
`ifdef MINMAX_TIE_COUNT_EN
      tieCount_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      count_q <= count_d;
      first_q <= first_d;
`ifdef MINMAX_TIE_COUNT_EN
      tieCount_q <= tieCount_d;
`endif
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.busy      = inReady;
  assign bus.done      = (state_q == S_DONE);
  assign bus.max_out   = max_q;
  assign bus.min_out   = min_q;
  assign bus.count_out = count_q;
`ifdef MINMAX_TIE_COUNT_EN
  assign bus.tie_count_out = tieCount_q;
`endif

endmodule

// File: tb/tb_minmax_tracker_4bit.sv
// Bench for minmax_tracker_4bit: WINDOW=4 and WINDOW=1 instances, plus a
// WINDOW=5 instance when MINMAX_TIE_COUNT_EN is defined.
module tb_minmax_tracker_4bit;
  import minmax_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  minmax_tracker_4bit_if #(.CNT_W(4)) bus4 ();
  minmax_tracker_4bit_if #(.CNT_W(4)) bus1 ();

  minmax_tracker_4bit #(.WINDOW(4), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  minmax_tracker_4bit #(.WINDOW(1), .CNT_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

`ifdef MINMAX_TIE_COUNT_EN
  minmax_tracker_4bit_if #(.CNT_W(4)) bus5 ();

  minmax_tracker_4bit #(.WINDOW(5), .CNT_W(4)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] eMax;
    logic [3:0] eMin;
    logic [3:0] eCnt;
  } result_t;

  typedef struct {
    logic [15:0] samples;
    int          gap;
    logic [3:0]  eMax;
    logic [3:0]  eMin;
  } vector_t;

  result_t sb[$];
  vector_t vectors[7];

  // Single comparison point; every failure prints one FAIL line
  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: each done pulse of the WINDOW=4 instance retires one result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus4.done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 4'(bus4.done), 4'd0);
      end else begin
        result_t r;
        r = sb.pop_front();
        checkOutput("sbMax", bus4.max_out, r.eMax);
        checkOutput("sbMin", bus4.min_out, r.eMin);
        checkOutput("sbCount", bus4.count_out, r.eCnt);
      end
    end
  end

  // Feeds n samples (top nibble first) into bus4, checking count after each accept
  task automatic feedSamples(input logic [15:0] s, input int n, input int base, input int gap);
    for (int k = 0; k < n; k++) begin
      bus4.in_data  = s[15-4*k -: 4];
      bus4.in_valid = 1'b1;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      checkOutput("acceptCount", bus4.count_out, 4'(base + k + 1));
      if (base + k + 1 == 4) begin
        checkOutput("donePulse", 4'(bus4.done), 4'd1);
      end else begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checkOutput("stallCount", bus4.count_out, 4'(base + k + 1));
        end
      end
    end
  endtask

  // After a window closes: DONE must have lasted one cycle and results must hold
  task automatic checkIdleHold(input logic [3:0] eMax, input logic [3:0] eMin);
    @(negedge clk);
    checkOutput("idleDone", 4'(bus4.done), 4'd0);
    checkOutput("idleBusy", 4'(bus4.busy), 4'd0);
    checkOutput("idleReady", 4'(bus4.in_ready), 4'd0);
    checkOutput("holdMax", bus4.max_out, eMax);
    checkOutput("holdMin", bus4.min_out, eMin);
    checkOutput("holdCount", bus4.count_out, 4'd4);
  endtask

  // One full window from IDLE with its expected result queued on the scoreboard
  task automatic applyStimulus(input vector_t v);
    sb.push_back('{v.eMax, v.eMin, 4'd4});
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    checkOutput("startBusy", 4'(bus4.busy), 4'd1);
    checkOutput("startCount", bus4.count_out, 4'd0);
    feedSamples(v.samples, 4, 0, v.gap);
    checkIdleHold(v.eMax, v.eMin);
  endtask

  // Start high during DONE chains a second window; old results hold until its first accept
  task automatic backToBack();
    sb.push_back('{4'hE, 4'h1, 4'd4});
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    feedSamples(16'h1E35, 4, 0, 0);
    sb.push_back('{4'h8, 4'h8, 4'd4});
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    checkOutput("b2bBusy", 4'(bus4.busy), 4'd1);
    checkOutput("b2bCount", bus4.count_out, 4'd0);
    checkOutput("b2bHoldMax", bus4.max_out, 4'hE);
    checkOutput("b2bHoldMin", bus4.min_out, 4'h1);
    @(negedge clk);
    checkOutput("b2bHoldMax2", bus4.max_out, 4'hE);
    checkOutput("b2bHoldMin2", bus4.min_out, 4'h1);
    feedSamples(16'h8888, 4, 0, 0);
    checkIdleHold(4'h8, 4'h8);
  endtask

  // in_valid in IDLE and start mid-window must both be ignored
  task automatic ignoredInputs();
    bus4.in_data  = 4'hF;
    bus4.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idleValidCount", bus4.count_out, 4'd4);
      checkOutput("idleValidMax", bus4.max_out, 4'h8);
      checkOutput("idleValidMin", bus4.min_out, 4'h8);
    end
    bus4.in_valid = 1'b0;
    sb.push_back('{4'hA, 4'h3, 4'd4});
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    feedSamples(16'h7300, 2, 0, 0);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    checkOutput("midStartCount", bus4.count_out, 4'd2);
    checkOutput("midStartBusy", 4'(bus4.busy), 4'd1);
    @(negedge clk);
    checkOutput("midStartCount2", bus4.count_out, 4'd2);
    checkOutput("midStartMax", bus4.max_out, 4'h7);
    feedSamples(16'hA500, 2, 2, 0);
    checkIdleHold(4'hA, 4'h3);
  endtask

  // Reset between clock edges must clear everything at once
  task automatic resetMidWindow();
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    feedSamples(16'hC400, 2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstMax", bus4.max_out, 4'h0);
    checkOutput("rstMin", bus4.min_out, 4'hF);
    checkOutput("rstCount", bus4.count_out, 4'd0);
    checkOutput("rstDone", 4'(bus4.done), 4'd0);
    checkOutput("rstBusy", 4'(bus4.busy), 4'd0);
    checkOutput("rstReady", 4'(bus4.in_ready), 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstBusy", 4'(bus4.busy), 4'd0);
  endtask

  // WINDOW=1: done directly follows the single accept
  task automatic windowOne(input logic [3:0] sample);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.in_data  = sample;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    checkOutput("w1Done", 4'(bus1.done), 4'd1);
    checkOutput("w1Max", bus1.max_out, sample);
    checkOutput("w1Min", bus1.min_out, sample);
    checkOutput("w1Count", bus1.count_out, 4'd1);
    checkOutput("w1Ready", 4'(bus1.in_ready), 4'd0);
    @(negedge clk);
    checkOutput("w1DoneLow", 4'(bus1.done), 4'd0);
    checkOutput("w1Idle", 4'(bus1.busy), 4'd0);
  endtask

`ifdef MINMAX_TIE_COUNT_EN
  // Ties against the running max are counted, cleared at the next window start
  task automatic tieTest();
    logic [19:0] s;
    s = 20'h66469;
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus5.in_data  = s[19-4*k -: 4];
      bus5.in_valid = 1'b1;
      @(negedge clk);
    end
    bus5.in_valid = 1'b0;
    checkOutput("tieDone", 4'(bus5.done), 4'd1);
    checkOutput("tieCount", bus5.tie_count_out, 4'd2);
    checkOutput("tieMax", bus5.max_out, 4'h9);
    checkOutput("tieMin", bus5.min_out, 4'h4);
    checkOutput("tieSamples", bus5.count_out, 4'd5);
    @(negedge clk);
    checkOutput("tieHold", bus5.tie_count_out, 4'd2);
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    checkOutput("tieCleared", bus5.tie_count_out, 4'd0);
  endtask
`endif

  // Hard stop in case something wedges the sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    vectors[0] = '{16'h5292, 0, 4'h9, 4'h2};
    vectors[1] = '{16'h3C17, 2, 4'hC, 4'h1};
    vectors[2] = '{16'hF0F0, 1, 4'hF, 4'h0};
    vectors[3] = '{16'h0000, 0, 4'h0, 4'h0};
    vectors[4] = '{16'h1234, 0, 4'h4, 4'h1};
    vectors[5] = '{16'hA9B8, 1, 4'hB, 4'h8};
    vectors[6] = '{16'h7777, 0, 4'h7, 4'h7};

    rst_n         = 1'b0;
    bus4.start    = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_data  = 4'h0;
    bus1.start    = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 4'h0;
`ifdef MINMAX_TIE_COUNT_EN
    bus5.start    = 1'b0;
    bus5.in_valid = 1'b0;
    bus5.in_data  = 4'h0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("resetMax", bus4.max_out, 4'h0);
    checkOutput("resetMin", bus4.min_out, 4'hF);
    checkOutput("resetCount", bus4.count_out, 4'd0);
    checkOutput("resetDone", 4'(bus4.done), 4'd0);
    checkOutput("resetBusy", 4'(bus4.busy), 4'd0);
    checkOutput("resetReady", 4'(bus4.in_ready), 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vectors[i]);
    end

    backToBack();
    ignoredInputs();
    resetMidWindow();
    windowOne(4'h7);
    windowOne(4'h3);
`ifdef MINMAX_TIE_COUNT_EN
    tieTest();
`endif

    @(negedge clk);
    checkOutput("sbDrain", 4'(sb.size()), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
